// File: rtl/dmu_pkg.sv
// Shared types for the data memory unit: FSM states, access sizes, Funct3 codes.
// Pure declarations and helpers, no logic of its own.
// Imported by data_mem_unit and dmu_lane_align.
package dmu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } dmu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Undefined encodings (011, 110, 111) fall through to a full-word access.
  function automatic size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: f3_size = SZ_B;
      F3_H, F3_HU: f3_size = SZ_H;
      default:     f3_size = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/dmu_lane_align.sv
// Lane steering: shifts store data into its byte lane and builds byte enables;
// extracts and sign/zero-extends load data. Purely combinational, no state.
// Ports: i_size/i_unsigned/i_addr_lo select the lane; i_store_data -> o_wdata/o_be;
//        i_load_word -> o_load_data.
module dmu_lane_align
  import dmu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]         i_addr_lo,
  input  size_e              i_size,
  input  logic               i_unsigned,
  input  logic [WIDTH-1:0]   i_store_data,
  input  logic [WIDTH-1:0]   i_load_word,
  output logic [WIDTH-1:0]   o_wdata,
  output logic [WIDTH/8-1:0] o_be,
  output logic [WIDTH-1:0]   o_load_data
);

  localparam int BEW = WIDTH / 8;

  logic [4:0]       w_byte_sh;
  logic [4:0]       w_half_sh;
  logic [WIDTH-1:0] w_ld_b;
  logic [WIDTH-1:0] w_ld_h;

  // Bit offsets of the selected byte / halfword inside the word.
  assign w_byte_sh = {i_addr_lo, 3'b000};
  assign w_half_sh = {i_addr_lo[1], 4'b0000};

  assign w_ld_b = i_load_word >> w_byte_sh;
  assign w_ld_h = i_load_word >> w_half_sh;

  always_comb begin
    o_wdata     = i_store_data;
    o_be        = {BEW{1'b1}};
    o_load_data = i_load_word;
    case (i_size)
      SZ_B: begin
        o_wdata     = WIDTH'(i_store_data[7:0]) << w_byte_sh;
        o_be        = BEW'(1) << i_addr_lo;
        o_load_data = {{(WIDTH-8){~i_unsigned & w_ld_b[7]}}, w_ld_b[7:0]};
      end
      SZ_H: begin
        o_wdata     = WIDTH'(i_store_data[15:0]) << w_half_sh;
        o_be        = BEW'(3) << {i_addr_lo[1], 1'b0};
        o_load_data = {{(WIDTH-16){~i_unsigned & w_ld_h[15]}}, w_ld_h[15:0]};
      end
      default: begin
        o_wdata     = i_store_data;
        o_be        = {BEW{1'b1}};
        o_load_data = i_load_word;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Load/store stage: runs B/H/W accesses over a req/gnt/rvalid bus and returns the
// registered, extended load result. Ports: core side (read_en, write_en, Funct3,
// Mem_addr_out, RS2_data_out -> dmu_out_data, dmu_valid, stall, bus_err), bus side
// (mem_* signals). Optional MISALIGN_TRAP_EN adds misalign_err and skips the bus
// for misaligned H/W accesses; without it low address bits are ignored.
module data_mem_unit
  import dmu_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read_en,
  input  logic               write_en,
  input  logic [2:0]         Funct3,
  input  logic [WIDTH-1:0]   Mem_addr_out,
  input  logic [WIDTH-1:0]   RS2_data_out,
  output logic [WIDTH-1:0]   dmu_out_data,
  output logic               dmu_valid,
  output logic               stall,
  output logic               bus_err,
  output logic               mem_req,
  output logic               mem_we,
  output logic [WIDTH-1:0]   mem_addr,
  output logic [WIDTH-1:0]   mem_wdata,
  output logic [WIDTH/8-1:0] mem_be,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [WIDTH-1:0]   mem_rdata
`ifdef MISALIGN_TRAP_EN
  ,
  output logic               misalign_err
`endif
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  dmu_state_e       r_state, w_next;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [2:0]       r_f3;
  logic             r_we;
  logic [CW-1:0]    r_cnt;
  logic             r_timeout;
  logic             r_misalign;
  logic [WIDTH-1:0] r_dout;

  logic             w_start;
  logic             w_misalign;
  logic             w_tmo_hit;
  logic             w_load_cap;
  logic             w_tmo_abort;
  logic             w_in_req;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH/8-1:0] w_be;
  logic [WIDTH-1:0] w_load_data;

  assign w_start   = read_en | write_en;
  assign w_in_req  = (r_state == ST_REQ);
  assign w_tmo_hit = (r_cnt >= CW'(TIMEOUT_CYCLES - 1));

`ifdef MISALIGN_TRAP_EN
  // Misalignment is judged on the live inputs so the access never reaches the bus.
  assign w_misalign = (r_state == ST_IDLE) & w_start &
                      (((f3_size(Funct3) == SZ_H) & Mem_addr_out[0]) |
                       ((f3_size(Funct3) == SZ_W) & (Mem_addr_out[1:0] != 2'b00)));
  assign misalign_err = r_misalign;
`else
  assign w_misalign = 1'b0;
`endif

  // A load completes either on rvalid in WAIT or on rvalid arriving with gnt.
  assign w_load_cap = ~r_we & ((w_in_req & mem_gnt & mem_rvalid) |
                               ((r_state == ST_WAIT) & mem_rvalid));

  // Timeout only aborts when the bus did not make progress in that same cycle.
  assign w_tmo_abort = w_tmo_hit & ((w_in_req & ~mem_gnt) |
                                    ((r_state == ST_WAIT) & ~mem_rvalid));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_next = w_misalign ? ST_DONE : ST_REQ;
      ST_REQ: begin
        if (mem_gnt)          w_next = (r_we | mem_rvalid) ? ST_DONE : ST_WAIT;
        else if (w_tmo_abort) w_next = ST_DONE;
      end
      ST_WAIT: if (mem_rvalid | w_tmo_abort) w_next = ST_DONE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_f3       <= '0;
      r_we       <= 1'b0;
      r_cnt      <= '0;
      r_timeout  <= 1'b0;
      r_misalign <= 1'b0;
      r_dout     <= '0;
    end else begin
      r_state    <= w_next;
      // Both flags are high only for the single DONE cycle that follows their cause.
      r_timeout  <= w_tmo_abort;
      r_misalign <= w_misalign;
      if (r_state == ST_IDLE) begin
        r_cnt <= '0;
        if (w_start) begin
          r_addr  <= Mem_addr_out;
          r_wdata <= RS2_data_out;
          r_f3    <= Funct3;
          r_we    <= write_en;
        end
      end else if ((r_state == ST_REQ) || (r_state == ST_WAIT)) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_load_cap)                r_dout <= w_load_data;
      else if (w_tmo_abort && !r_we) r_dout <= '0;
    end
  end

  dmu_lane_align #(.WIDTH(WIDTH)) u_lane (
    .i_addr_lo    (r_addr[1:0]),
    .i_size       (f3_size(r_f3)),
    .i_unsigned   (r_f3[2]),
    .i_store_data (r_wdata),
    .i_load_word  (mem_rdata),
    .o_wdata      (w_wdata),
    .o_be         (w_be),
    .o_load_data  (w_load_data)
  );

  // Bus outputs are zero outside REQ so the bus sees nothing stale.
  assign mem_req   = w_in_req;
  assign mem_we    = w_in_req & r_we;
  assign mem_addr  = w_in_req ? {r_addr[WIDTH-1:2], 2'b00} : '0;
  assign mem_wdata = (w_in_req & r_we) ? w_wdata : '0;
  assign mem_be    = (w_in_req & r_we) ? w_be : '0;

  assign dmu_out_data = r_dout;
  assign dmu_valid    = (r_state == ST_DONE);
  assign bus_err      = r_timeout;
  // rst gates stall so the core is released the instant an access is abandoned.
  assign stall        = ~rst & (((r_state == ST_IDLE) & w_start) | w_in_req |
                                (r_state == ST_WAIT));

endmodule

// File: tb/tb_data_mem_unit.sv
module tb_data_mem_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read_en = 1'b0, write_en = 1'b0;
  logic [2:0]  Funct3 = '0;
  logic [31:0] Mem_addr_out = '0, RS2_data_out = '0;
  logic [31:0] dmu_out_data;
  logic        dmu_valid, stall, bus_err, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        misalign_w;

  int tests_run = 0;
  int fails = 0;

  // Results of the most recent run_access call.
  int          lat;
  logic        req_seen, we_seen, berr_seen, merr_seen, stall_done;
  logic [3:0]  be_seen;
  logic [31:0] wdata_seen, addr_seen, dout_seen;

  always #5 clk = ~clk;

  data_mem_unit #(.WIDTH(32), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst(rst), .read_en(read_en), .write_en(write_en), .Funct3(Funct3),
    .Mem_addr_out(Mem_addr_out), .RS2_data_out(RS2_data_out),
    .dmu_out_data(dmu_out_data), .dmu_valid(dmu_valid), .stall(stall), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef MISALIGN_TRAP_EN
    , .misalign_err(misalign_w)
`endif
  );

`ifndef MISALIGN_TRAP_EN
  assign misalign_w = 1'b0;
`endif

  // Drives one access and acts as the bus slave. gnt_dly<0: never grant.
  // rv_dly<0: rvalid together with gnt. lat = edges until dmu_valid, -1 if it never came.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                            input logic [31:0] rdata);
    int rq, wt;
    logic granted, done;
    rq = 0; wt = 0; granted = 0; done = 0;
    req_seen = 0; we_seen = 0; be_seen = '0; wdata_seen = '0; addr_seen = '0;
    berr_seen = 0; merr_seen = 0; stall_done = 1; dout_seen = '0;
    @(negedge clk);
    read_en = ~we; write_en = we; Funct3 = f3; Mem_addr_out = addr; RS2_data_out = wdata;
    lat = 0;
    while (!done && lat < 400) begin
      @(posedge clk); @(negedge clk);
      lat++;
      mem_gnt = 0; mem_rvalid = 0;
      if (dmu_valid) begin
        done = 1; dout_seen = dmu_out_data; berr_seen = bus_err;
        merr_seen = misalign_w; stall_done = stall;
      end else if (mem_req) begin
        req_seen = 1; we_seen = mem_we; be_seen = mem_be; wdata_seen = mem_wdata;
        addr_seen = mem_addr; rq++;
        if (gnt_dly >= 0 && rq > gnt_dly) begin
          mem_gnt = 1; granted = 1;
          if (!we && rv_dly < 0) begin mem_rvalid = 1; mem_rdata = rdata; end
        end
      end else if (granted) begin
        wt++;
        if (wt > rv_dly) begin mem_rvalid = 1; mem_rdata = rdata; end
      end
    end
    if (!done) lat = -1;
    read_en = 0; write_en = 0; mem_gnt = 0; mem_rvalid = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({dmu_out_data, dmu_valid, stall, bus_err, mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== '0) begin
      fails++; $display("FAIL reset_outputs: got req=%b stall=%b valid=%b be=%b data=%h, want all 0",
                        mem_req, stall, dmu_valid, mem_be, dmu_out_data);
    end
    rst = 0;
  endtask

  task automatic test_store_word();
    run_access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1, 0, 32'h0);
    tests_run++;
    if (lat !== 3) begin fails++; $display("FAIL sw_latency: got %0d want 3", lat); end
    tests_run++;
    if ({we_seen, be_seen, wdata_seen, addr_seen} !== {1'b1, 4'b1111, 32'hDEADBEEF, 32'h100}) begin
      fails++; $display("FAIL sw_bus: we=%b be=%b wdata=%h addr=%h want 1 1111 deadbeef 00000100",
                        we_seen, be_seen, wdata_seen, addr_seen);
    end
  endtask

  task automatic test_load_byte();
    run_access(1'b0, 3'b000, 32'h103, 32'h0, 1, 1, 32'h80FFFF00);
    tests_run++;
    if (dout_seen !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_sext: got %h want ffffff80", dout_seen); end
    tests_run++;
    if ({we_seen, be_seen, addr_seen} !== {1'b0, 4'b0000, 32'h100}) begin
      fails++; $display("FAIL lb_bus: we=%b be=%b addr=%h want 0 0000 00000100", we_seen, be_seen, addr_seen);
    end
    tests_run++;
    if (lat !== 5) begin fails++; $display("FAIL lb_latency: got %0d want 5", lat); end
    run_access(1'b0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80FFFF00);
    tests_run++;
    if (dout_seen !== 32'h00000080) begin fails++; $display("FAIL lbu_zext: got %h want 00000080", dout_seen); end
  endtask

  task automatic test_half();
    run_access(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 0, 0, 32'h0);
    tests_run++;
    if ({be_seen, wdata_seen} !== {4'b1100, 32'hABCD0000}) begin
      fails++; $display("FAIL sh_lane: be=%b wdata=%h want 1100 abcd0000", be_seen, wdata_seen);
    end
    tests_run++;
    if (dout_seen !== 32'h00000080) begin fails++; $display("FAIL store_holds_dout: got %h want 00000080", dout_seen); end
    run_access(1'b0, 3'b101, 32'h102, 32'h0, 0, 0, 32'hABCD0000);
    tests_run++;
    if (dout_seen !== 32'h0000ABCD) begin fails++; $display("FAIL lhu_zext: got %h want 0000abcd", dout_seen); end
    run_access(1'b0, 3'b001, 32'h102, 32'h0, 0, 0, 32'hABCD0000);
    tests_run++;
    if (dout_seen !== 32'hFFFFABCD) begin fails++; $display("FAIL lh_sext: got %h want ffffabcd", dout_seen); end
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 3'b000, 32'h101, 32'h000000A5, 0, 0, 32'h0);
    tests_run++;
    if ({lat, be_seen, wdata_seen} !== {32'd2, 4'b0010, 32'h0000A500}) begin
      fails++; $display("FAIL sb_min: lat=%0d be=%b wdata=%h want 2 0010 0000a500", lat, be_seen, wdata_seen);
    end
    run_access(1'b0, 3'b010, 32'h200, 32'h0, 0, 0, 32'h12345678);
    tests_run++;
    if ({lat, dout_seen} !== {32'd3, 32'h12345678}) begin
      fails++; $display("FAIL lw_min: lat=%0d data=%h want 3 12345678", lat, dout_seen);
    end
    run_access(1'b0, 3'b010, 32'h204, 32'h0, 0, -1, 32'h9ABCDEF0);
    tests_run++;
    if ({lat, dout_seen} !== {32'd2, 32'h9ABCDEF0}) begin
      fails++; $display("FAIL lw_gnt_rvalid_same: lat=%0d data=%h want 2 9abcdef0", lat, dout_seen);
    end
    run_access(1'b1, 3'b111, 32'h208, 32'hCAFEBABE, 0, 0, 32'h0);
    tests_run++;
    if ({be_seen, wdata_seen} !== {4'b1111, 32'hCAFEBABE}) begin
      fails++; $display("FAIL undef_f3_word: be=%b wdata=%h want 1111 cafebabe", be_seen, wdata_seen);
    end
  endtask

  task automatic test_timeout();
    run_access(1'b0, 3'b010, 32'h300, 32'h0, 0, 0, 32'h55AA55AA);
    tests_run++;
    if (dout_seen !== 32'h55AA55AA) begin fails++; $display("FAIL pre_timeout_load: got %h want 55aa55aa", dout_seen); end
    run_access(1'b0, 3'b010, 32'h304, 32'h0, -1, 0, 32'h0);
    tests_run++;
    if ({lat, berr_seen, stall_done, dout_seen} !== {32'd256, 1'b1, 1'b0, 32'h0}) begin
      fails++; $display("FAIL timeout: lat=%0d bus_err=%b stall=%b data=%h want 256 1 0 00000000",
                        lat, berr_seen, stall_done, dout_seen);
    end
    @(negedge clk);
    tests_run++;
    if ({bus_err, dmu_valid, stall} !== 3'b000) begin
      fails++; $display("FAIL timeout_pulse: bus_err=%b valid=%b stall=%b want 000", bus_err, dmu_valid, stall);
    end
  endtask

  task automatic test_reset_mid_access();
    run_access(1'b0, 3'b010, 32'h400, 32'h0, 0, 0, 32'h13579BDF);
    @(negedge clk);
    read_en = 1; Funct3 = 3'b010; Mem_addr_out = 32'h404;
    @(posedge clk); @(negedge clk);
    read_en = 0;
    mem_gnt = mem_req;
    @(posedge clk); @(negedge clk);
    mem_gnt = 0;
    tests_run++;
    if ({mem_req, stall} !== 2'b01) begin fails++; $display("FAIL wait_state: req=%b stall=%b want 0 1", mem_req, stall); end
    #2 rst = 1;
    #1;
    tests_run++;
    if ({mem_req, stall, dmu_valid, dmu_out_data} !== {3'b000, 32'h0}) begin
      fails++; $display("FAIL rst_mid_wait: req=%b stall=%b valid=%b data=%h want 0 0 0 00000000",
                        mem_req, stall, dmu_valid, dmu_out_data);
    end
    @(negedge clk);
    rst = 0;
    run_access(1'b0, 3'b010, 32'h408, 32'h0, 0, 0, 32'h2468ACE0);
    tests_run++;
    if ({lat, dout_seen} !== {32'd3, 32'h2468ACE0}) begin
      fails++; $display("FAIL lw_after_rst: lat=%0d data=%h want 3 2468ace0", lat, dout_seen);
    end
  endtask

  task automatic test_misalign();
    run_access(1'b0, 3'b010, 32'h500, 32'h0, 0, 0, 32'h0BADF00D);
    run_access(1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h11223344);
`ifdef MISALIGN_TRAP_EN
    tests_run++;
    if ({lat, req_seen, merr_seen, dout_seen} !== {32'd1, 1'b0, 1'b1, 32'h0BADF00D}) begin
      fails++; $display("FAIL misalign_trap: lat=%0d req=%b merr=%b data=%h want 1 0 1 0badf00d",
                        lat, req_seen, merr_seen, dout_seen);
    end
`else
    tests_run++;
    if ({lat, addr_seen, dout_seen} !== {32'd3, 32'h100, 32'h11223344}) begin
      fails++; $display("FAIL misalign_ignored: lat=%0d addr=%h data=%h want 3 00000100 11223344",
                        lat, addr_seen, dout_seen);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_half();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
